depth_frame_streamer: RTL and testbench
=======================================

Name: depth_frame_streamer

Overview:
- Transmit side of the DEPTH XDS pixel stream; the counterpart of the depth histogram receiver.
- Reads a raster depth image from a single-port depth SRAM (1-cycle read latency).
- Emits the image as a valid/ready pixel stream framed by one-cycle FRAME_START / FRAME_FINISH pulses.
- Used in the bench as the stimulus source for the histogram DUT, and in silicon as the frame replay path.

Parameters:
- p_depth_bit, 8, bits per depth pixel (= SRAM data width)
- p_dim_bit, 8, width of i_WIDTH / i_HEIGHT
- p_depth_sram_a_bit, 16, SRAM address width; must satisfy 2^a ≥ (2^p_dim_bit−1)^2

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  asynchronous active-low reset
- i_WIDTH  in  p_dim_bit  frame width in pixels, sampled on start
- i_HEIGHT  in  p_dim_bit  frame height in rows, sampled on start
- i_START  in  1  start request; accepted only while o_BUSY=0
- o_BUSY  out  1  frame in progress
- o_FRAME_START  out  1  one-cycle pulse, frame begins
- o_FRAME_FINISH  out  1  one-cycle pulse, last pixel delivered
- o_DEPTH_XDS_OUT_VALID  out  1  pixel valid
- i_DEPTH_XDS_OUT_READY  in  1  sink ready
- o_DEPTH  out  p_depth_bit  pixel value
- o_DEPTH_SRAM_CEN  out  1  SRAM chip enable, active low
- o_DEPTH_SRAM_WEN  out  1  constant 1 (read only)
- o_DEPTH_SRAM_A  out  p_depth_sram_a_bit  read address
- i_DEPTH_SRAM_Q  in  p_depth_bit  read data, valid the cycle after a CEN=0 read

Behaviour:
- Reset values (async, any time, including mid-frame):
  - o_BUSY, o_FRAME_START, o_FRAME_FINISH, o_DEPTH_XDS_OUT_VALID = 0
  - o_DEPTH = 0, o_DEPTH_SRAM_CEN = 1, o_DEPTH_SRAM_A = 0
  - FIFO and credits cleared, FSM → IDLE. No pulse is generated on reset exit.
- FSM states IDLE, STREAM, FINISH.
- IDLE: if i_START=1 at a clock edge, latch W=i_WIDTH and H=i_HEIGHT.
  - W=0 or H=0 → go to FINISH (empty frame).
  - Otherwise → go to STREAM.
  - In both cases o_FRAME_START=1 and o_BUSY=1 for the next cycle.
- STREAM reads:
  - Addresses issued in raster order 0..W*H−1, incremented by 1 per issued read.
  - Column/row counters detect the end of the frame; no multiplier.
  - The first read (A=0, CEN=0) is issued in the same cycle as o_FRAME_START.
- Read credit scheme:
  - Read data is captured into a 2-entry FIFO.
  - A read is issued in a cycle iff addresses remain and (fifo_count + inflight − pop_this_cycle) < 2.
  - inflight is 0 or 1.
  - This gives full throughput (1 pixel/cycle) with ready held high, and no data loss under backpressure.
- Output stream:
  - o_DEPTH_XDS_OUT_VALID = FIFO non-empty; o_DEPTH = FIFO head.
  - Handshake occurs when VALID & READY.
  - Once VALID=1 it holds, with o_DEPTH stable, until the handshake.
  - The first VALID appears 2 cycles after o_FRAME_START.
- STREAM → FINISH in the cycle of the W*H-th handshake.
- FINISH: o_FRAME_FINISH=1 for exactly one cycle; o_BUSY still 1. Next state IDLE with o_BUSY=0.
- Earliest restart: a new i_START is accepted in the first IDLE cycle. i_START while busy is ignored (not queued).
- Changes on i_WIDTH / i_HEIGHT during a frame have no effect.
- Maximum frame: W=H=2^p_dim_bit−1. The address counter never wraps within a frame.

Optional Feature:
- Macro DEPTH_STREAM_EOL_EN.
- When defined:
  - Adds output port o_DEPTH_EOL (1 bit), carried through the FIFO alongside o_DEPTH.
  - o_DEPTH_EOL is high with the last pixel of each row (column == W−1) and valid-qualified.
  - Reset value 0.
- When undefined: the port and the extra FIFO bit are absent; behaviour is otherwise identical.

Decomposition:
- dut_param_pkg gets p_dim_bit and the typedef enum for the FSM states (IDLE/STREAM/FINISH). Existing p_depth_bit / p_depth_sram_a_bit are reused.
- One sub-module: depth_stream_skid, a 2-entry synchronous FIFO with async active-low reset.
  - Ports: push, data_in, pop, data_out, count.
  - Parameterised data width, so the EOL bit can be appended.

Test Plan:
- W=4, H=3, SRAM[i]=i, ready=1:
  - FRAME_START at cycle t; pixels 0..11 on consecutive cycles t+2..t+13.
  - FRAME_FINISH at t+14; BUSY low at t+15.
- Same frame with ready toggling 1,0,0,1,…:
  - Values 0..11 in order, no drops or duplicates.
  - o_DEPTH stable while VALID & !READY.
  - At most 2 reads outstanding (fifo + inflight ≤ 2).
- W=0, H=5:
  - FRAME_START at t, FRAME_FINISH at t+1, no VALID, CEN never asserted.
- i_START pulsed mid-frame with W=2, H=2, then i_WIDTH changed:
  - Ignored; exactly 4 pixels emitted.
  - A back-to-back restart in the first IDLE cycle is accepted.
- i_RSTn asserted after pixel 5 of a 4×3 frame:
  - Outputs go to reset values asynchronously.
  - A new start then streams from address 0.
- DEPTH_STREAM_EOL_EN, W=3, H=2:
  - o_DEPTH_EOL high only on pixels at addresses 2 and 5.

Source files
------------

// File: rtl/dut_param_pkg.sv
// Shared constants and FSM state type for the depth frame streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dut_param_pkg;

  localparam int c_depth_bit        = 8;
  localparam int c_dim_bit          = 8;
  localparam int c_depth_sram_a_bit = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/depth_stream_skid.sv
// Two-entry synchronous FIFO holding SRAM read data until the sink takes it.
// Latency: a push is visible on data_out the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module depth_stream_skid #(
  parameter int p_width = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [p_width-1:0] data_in,
  input  logic               pop,
  output logic [p_width-1:0] data_out,
  output logic [1:0]         count
);

  logic [p_width-1:0] mem_q [2];
  logic [p_width-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;

  // Next-state: write slot on push, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_out = mem_q[rd_ptr_q];
  assign count    = cnt_q;

endmodule

// File: rtl/depth_frame_streamer.sv
// Streams a W x H raster depth image from SRAM as a framed valid/ready pixel stream.
// Latency: first read with FRAME_START, first VALID 2 cycles later, 1 pixel/cycle with ready high.
// Backpressure: read credits (fifo + inflight <= 2) stall SRAM reads; no data loss. Macro DEPTH_STREAM_EOL_EN adds o_DEPTH_EOL.
module depth_frame_streamer
  import dut_param_pkg::*;
#(
  parameter int p_depth_bit        = c_depth_bit,
  parameter int p_dim_bit          = c_dim_bit,
  parameter int p_depth_sram_a_bit = c_depth_sram_a_bit
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [p_dim_bit-1:0]          i_WIDTH,
  input  logic [p_dim_bit-1:0]          i_HEIGHT,
  input  logic                          i_START,
  output logic                          o_BUSY,
  output logic                          o_FRAME_START,
  output logic                          o_FRAME_FINISH,
  output logic                          o_DEPTH_XDS_OUT_VALID,
  input  logic                          i_DEPTH_XDS_OUT_READY,
  output logic [p_depth_bit-1:0]        o_DEPTH,
  output logic                          o_DEPTH_SRAM_CEN,
  output logic                          o_DEPTH_SRAM_WEN,
  output logic [p_depth_sram_a_bit-1:0] o_DEPTH_SRAM_A,
  input  logic [p_depth_bit-1:0]        i_DEPTH_SRAM_Q
`ifdef DEPTH_STREAM_EOL_EN
  ,
  output logic                          o_DEPTH_EOL
`endif
);

  // FIFO entry: {eol (optional), last-of-frame, pixel}.
`ifdef DEPTH_STREAM_EOL_EN
  localparam int c_fifo_w = p_depth_bit + 2;
`else
  localparam int c_fifo_w = p_depth_bit + 1;
`endif

  localparam logic [p_dim_bit-1:0]          c_dim_one  = {{(p_dim_bit-1){1'b0}}, 1'b1};
  localparam logic [p_depth_sram_a_bit-1:0] c_addr_one = {{(p_depth_sram_a_bit-1){1'b0}}, 1'b1};

  state_t                        state_q, state_d;
  logic [p_dim_bit-1:0]          w_q, w_d, h_q, h_d;
  logic [p_dim_bit-1:0]          col_q, col_d, row_q, row_d;
  logic [p_depth_sram_a_bit-1:0] addr_q, addr_d;
  logic                          rd_left_q, rd_left_d;
  logic                          inflight_q, inflight_d;
  logic                          infl_last_q, infl_last_d;
  logic                          frame_start_q, frame_start_d;
`ifdef DEPTH_STREAM_EOL_EN
  logic                          infl_eol_q, infl_eol_d;
`endif

  logic [c_fifo_w-1:0] fifo_in, fifo_out;
  logic [1:0]          fifo_cnt;
  logic                fifo_vld, pop, issue, head_last;
  logic                col_last, row_last;
  logic [2:0]          credit;

  assign fifo_vld  = (fifo_cnt != 2'd0);
  assign pop       = fifo_vld & i_DEPTH_XDS_OUT_READY;
  assign head_last = fifo_out[p_depth_bit];
  assign col_last  = (col_q == (w_q - c_dim_one));
  assign row_last  = (row_q == (h_q - c_dim_one));

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign credit = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = (state_q == STREAM) && rd_left_q && (credit < 3'd2);

`ifdef DEPTH_STREAM_EOL_EN
  assign fifo_in = {infl_eol_q, infl_last_q, i_DEPTH_SRAM_Q};
`else
  assign fifo_in = {infl_last_q, i_DEPTH_SRAM_Q};
`endif

  depth_stream_skid #(
    .p_width (c_fifo_w)
  ) u_skid (
    .clk      (i_CLK),
    .rst_n    (i_RSTn),
    .push     (inflight_q),
    .data_in  (fifo_in),
    .pop      (pop),
    .data_out (fifo_out),
    .count    (fifo_cnt)
  );

  // Next-state: frame acceptance, raster read issue, and end-of-frame detection.
  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    h_d           = h_q;
    col_d         = col_q;
    row_d         = row_q;
    addr_d        = addr_q;
    rd_left_d     = rd_left_q;
    frame_start_d = 1'b0;
    inflight_d    = issue;
    infl_last_d   = issue & col_last & row_last;
`ifdef DEPTH_STREAM_EOL_EN
    infl_eol_d    = issue & col_last;
`endif
    case (state_q)
      IDLE: begin
        if (i_START) begin
          w_d           = i_WIDTH;
          h_d           = i_HEIGHT;
          col_d         = '0;
          row_d         = '0;
          addr_d        = '0;
          frame_start_d = 1'b1;
          if ((i_WIDTH == '0) || (i_HEIGHT == '0)) begin
            rd_left_d = 1'b0;
            state_d   = FINISH;
          end else begin
            rd_left_d = 1'b1;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (issue) begin
          addr_d = addr_q + c_addr_one;
          if (col_last) begin
            col_d = '0;
            row_d = row_q + c_dim_one;
            if (row_last) begin
              rd_left_d = 1'b0;
            end
          end else begin
            col_d = col_q + c_dim_one;
          end
        end
        if (pop && head_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // An empty frame enters here alongside FRAME_START; hold one more cycle so the pulses do not overlap.
        if (!frame_start_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset returns to IDLE with no pending reads.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q       <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      rd_left_q     <= 1'b0;
      inflight_q    <= 1'b0;
      infl_last_q   <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef DEPTH_STREAM_EOL_EN
      infl_eol_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      w_q           <= w_d;
      h_q           <= h_d;
      col_q         <= col_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      rd_left_q     <= rd_left_d;
      inflight_q    <= inflight_d;
      infl_last_q   <= infl_last_d;
      frame_start_q <= frame_start_d;
`ifdef DEPTH_STREAM_EOL_EN
      infl_eol_q    <= infl_eol_d;
`endif
    end
  end

  assign o_BUSY                = (state_q != IDLE);
  assign o_FRAME_START         = frame_start_q;
  assign o_FRAME_FINISH        = (state_q == FINISH) && !frame_start_q;
  assign o_DEPTH_XDS_OUT_VALID = fifo_vld;
  assign o_DEPTH               = fifo_out[p_depth_bit-1:0];
  assign o_DEPTH_SRAM_CEN      = ~issue;
  assign o_DEPTH_SRAM_WEN      = 1'b1;
  assign o_DEPTH_SRAM_A        = addr_q;
`ifdef DEPTH_STREAM_EOL_EN
  assign o_DEPTH_EOL           = fifo_vld & fifo_out[p_depth_bit+1];
`endif

endmodule

// File: tb/tb_depth_frame_streamer.sv
// Bench for depth_frame_streamer: table of frames against a raster-order reference model.
// Latency: checks start/first-valid/finish timing from the frame dimensions.
// Backpressure: drives steady, patterned and random ready; covers async reset mid-frame.
module tb_depth_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_width, i_height;
  logic        i_start;
  logic        busy, fs, ff, vld, rdy;
  logic [7:0]  depth;
  logic        cen, wen;
  logic [15:0] a;
  logic [7:0]  q;
`ifdef DEPTH_STREAM_EOL_EN
  logic        eol;
`endif

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single-port SRAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (!cen) q <= mem[a];
  end

  depth_frame_streamer dut (
    .i_CLK                 (clk),
    .i_RSTn                (rst_n),
    .i_WIDTH               (i_width),
    .i_HEIGHT              (i_height),
    .i_START               (i_start),
    .o_BUSY                (busy),
    .o_FRAME_START         (fs),
    .o_FRAME_FINISH        (ff),
    .o_DEPTH_XDS_OUT_VALID (vld),
    .i_DEPTH_XDS_OUT_READY (rdy),
    .o_DEPTH               (depth),
    .o_DEPTH_SRAM_CEN      (cen),
    .o_DEPTH_SRAM_WEN      (wen),
    .o_DEPTH_SRAM_A        (a),
    .i_DEPTH_SRAM_Q        (q)
`ifdef DEPTH_STREAM_EOL_EN
    ,
    .o_DEPTH_EOL           (eol)
`endif
  );

  typedef struct {
    int w;
    int h;
    int mode;     // 0: ready high, 1: pattern 1,0,0,1, 2: random
    int chain;    // start the next entry in the first IDLE cycle
    int poke;     // pulse start with new dimensions mid-frame
    int exp_pix;
    int exp_lat;  // FRAME_START to FRAME_FINISH in cycles, -1 = not checked
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_frame(input vec_t v, input bit skip, input int nw, input int nh);
    int npix, n_hs, n_rd, fin_cyc, fin_cnt, start_cnt, first_vld;
    int data_err, stab_err, addr_err, busy_err, max_out, eol_err, eol_cnt, budget;
    int start0, busy0, idle_after;
    bit prev_stall, done;
    logic [7:0] prev_depth;
    npix = v.w * v.h;
    for (int i = 0; i < npix; i++) mem[i] = 8'($urandom);
    n_hs = 0; n_rd = 0; fin_cyc = -1; fin_cnt = 0; start_cnt = 0; first_vld = -1;
    data_err = 0; stab_err = 0; addr_err = 0; busy_err = 0; max_out = 0;
    eol_err = 0; eol_cnt = 0; start0 = 0; busy0 = 0; idle_after = 0;
    prev_stall = 1'b0; done = 1'b0; prev_depth = '0;
    budget = 8 * npix + 40;
    if (!skip) begin
      @(posedge clk); #1;
      i_width = 8'(v.w); i_height = 8'(v.h); i_start = 1'b1;
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    rdy = ready_for(v.mode, 0);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        start0 = int'(fs);
        busy0  = int'(busy);
      end
      if (fs) start_cnt++;
      if (vld && first_vld < 0) first_vld = cyc;
      if (prev_stall && (!vld || depth !== prev_depth)) stab_err++;
      if (!cen) begin
        if (int'(a) != n_rd) addr_err++;
        n_rd++;
      end
`ifdef DEPTH_STREAM_EOL_EN
      if (!vld && eol) eol_err++;
`endif
      if (vld && rdy) begin
        if (depth !== mem[n_hs]) data_err++;
`ifdef DEPTH_STREAM_EOL_EN
        if (eol !== (((n_hs % v.w) == v.w - 1) ? 1'b1 : 1'b0)) eol_err++;
        if (eol) eol_cnt++;
`endif
        n_hs++;
      end
      if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
      prev_stall = vld && !rdy;
      prev_depth = depth;
      if (ff) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
        if (!busy) busy_err++;
      end
      if (fin_cyc >= 0 && cyc == fin_cyc + 1) begin
        idle_after = int'(!busy);
        done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        rdy = ready_for(v.mode, cyc + 1);
        i_start = 1'b0;
        if (v.poke != 0 && cyc == 1) begin
          i_start = 1'b1; i_width = 8'd9; i_height = 8'd9;
        end
        if (v.chain != 0 && cyc == fin_cyc) begin
          i_start = 1'b1; i_width = 8'(nw); i_height = 8'(nh);
        end
      end
    end
    check("frame_start_at_t", start0, 1);
    check("busy_at_t", busy0, 1);
    check("frame_start_count", start_cnt, 1);
    check("finish_seen", int'(fin_cyc >= 0), 1);
    check("finish_count", fin_cnt, 1);
    if (v.exp_lat >= 0) check("finish_latency", fin_cyc, v.exp_lat);
    check("busy_during_finish", busy_err, 0);
    check("busy_low_after_finish", idle_after, 1);
    check("pixel_count", n_hs, v.exp_pix);
    check("read_count", n_rd, v.exp_pix);
    check("pixel_data", data_err, 0);
    check("read_address_order", addr_err, 0);
    check("stall_stability", stab_err, 0);
    check("outstanding_le_2", int'(max_out <= 2), 1);
    if (v.exp_pix > 0) check("first_valid_cycle", first_vld, 2);
    else               check("no_valid_empty", first_vld, -1);
`ifdef DEPTH_STREAM_EOL_EN
    check("eol_flags", eol_err, 0);
    if (npix > 0) check("eol_count", eol_cnt, v.h);
`endif
  endtask

  initial begin
    int hs, pulses, guard;
    bit skip;

    vecs[0] = '{4,  3, 0, 0, 0, 12,  14};
    vecs[1] = '{4,  3, 1, 0, 0, 12,  -1};
    vecs[2] = '{0,  5, 0, 0, 0, 0,   1};
    vecs[3] = '{5,  0, 0, 0, 0, 0,   1};
    vecs[4] = '{2,  2, 0, 1, 1, 4,   6};
    vecs[5] = '{3,  1, 0, 0, 0, 3,   5};
    vecs[6] = '{1,  1, 2, 0, 0, 1,   -1};
    vecs[7] = '{7,  5, 2, 0, 0, 35,  -1};
    vecs[8] = '{16, 9, 0, 0, 0, 144, 146};
    vecs[9] = '{3,  2, 1, 0, 0, 6,   -1};

    rst_n = 1'b0; i_start = 1'b0; i_width = '0; i_height = '0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_frame_start", int'(fs), 0);
    check("rst_frame_finish", int'(ff), 0);
    check("rst_valid", int'(vld), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_cen", int'(cen), 1);
    check("rst_wen", int'(wen), 1);
    check("rst_addr", int'(a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_frame_start", int'(fs), 0);
    check("post_rst_busy", int'(busy), 0);

    for (int i = 0; i < NV; i++) begin
      skip = (i > 0) ? (vecs[i-1].chain != 0) : 1'b0;
      if (i + 1 < NV) run_frame(vecs[i], skip, vecs[i+1].w, vecs[i+1].h);
      else            run_frame(vecs[i], skip, 0, 0);
    end

    // Async reset after pixel 5 of a 4x3 frame, then a clean restart from address 0.
    for (int i = 0; i < 12; i++) mem[i] = 8'($urandom);
    @(posedge clk); #1;
    i_width = 8'd4; i_height = 8'd3; i_start = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    hs = 0; guard = 0;
    while (hs < 6 && guard < 60) begin
      @(negedge clk);
      if (vld && rdy) hs++;
      guard++;
    end
    check("reset_test_reached_pixel5", hs, 6);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_frame_start", int'(fs), 0);
    check("arst_frame_finish", int'(ff), 0);
    check("arst_valid", int'(vld), 0);
    check("arst_depth", int'(depth), 0);
    check("arst_cen", int'(cen), 1);
    check("arst_addr", int'(a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (fs || ff || busy || vld) pulses++;
    end
    check("no_activity_after_reset", pulses, 0);
    run_frame(vecs[0], 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
